// File: rtl/rgb565_gray_stream.sv
// RGB565 pixel stream to 8-bit luma with frame coordinate tagging.
// Two-stage stallable pipeline; the first stage registers weighted channel products and tags.
module rgb565_gray_stream #(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480,
  parameter int unsigned XW     = 10,
  parameter int unsigned YW     = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sync,
  input  logic [15:0]   in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic          out_sof,
  output logic          out_eol,
  output logic          out_eof,
  output logic          frame_err
);

  localparam int unsigned PW = 16;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
  localparam logic [PW-1:0] COEF_R = PW'(77);
  localparam logic [PW-1:0] COEF_G = PW'(150);
  localparam logic [PW-1:0] COEF_B = PW'(29);

  // Coordinate tracking state
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          locked_q, locked_d;
  logic          seen_sync_q, seen_sync_d;
  logic          drop_run_q, drop_run_d;
  logic          frame_err_q, frame_err_d;

  // Stage 1 registers
  logic          s1_valid_q;
  logic [PW-1:0] s1_r_q, s1_g_q, s1_b_q;
  logic [XW-1:0] s1_x_q;
  logic [YW-1:0] s1_y_q;
  logic          s1_sof_q, s1_eol_q, s1_eof_q;

  // Stage 2 (output) registers
  logic          out_valid_q;
  logic [7:0]    out_data_q;
  logic [XW-1:0] out_x_q;
  logic [YW-1:0] out_y_q;
  logic          out_sof_q, out_eol_q, out_eof_q;

  logic          advance_c;
  logic          accept_c;
  logic          keep_c;
  logic [XW-1:0] tag_x_c;
  logic [YW-1:0] tag_y_c;
  logic [7:0]    r8_c, g8_c, b8_c;

  assign advance_c = ~out_valid_q | out_ready;
  assign accept_c  = in_valid & advance_c;
  assign in_ready  = advance_c;

  // Replicate MSBs so full-scale channels map to 255
  assign r8_c = {in_data[15:11], in_data[15:13]};
  assign g8_c = {in_data[10:5],  in_data[10:9]};
  assign b8_c = {in_data[4:0],   in_data[4:2]};

  // Tag selection, lock tracking and framing-error detection for the accepted pixel
  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    locked_d    = locked_q;
    seen_sync_d = seen_sync_q;
    drop_run_d  = drop_run_q;
    frame_err_d = 1'b0;
    keep_c      = 1'b0;
    tag_x_c     = x_q;
    tag_y_c     = y_q;

    if (accept_c) begin
      if (in_sync) begin
        keep_c      = 1'b1;
        tag_x_c     = '0;
        tag_y_c     = '0;
        locked_d    = 1'b1;
        seen_sync_d = 1'b1;
        drop_run_d  = 1'b0;
        frame_err_d = locked_q & ((x_q != '0) | (y_q != '0));
      end else if (locked_q) begin
        keep_c = 1'b1;
      end else begin
        // Only the first pixel of a discarded run is an error, and only once a sync was seen
        frame_err_d = seen_sync_q & ~drop_run_q;
        drop_run_d  = 1'b1;
      end

      if (keep_c) begin
        if ((tag_x_c == X_LAST) && (tag_y_c == Y_LAST)) begin
          x_d      = '0;
          y_d      = '0;
          locked_d = 1'b0;
        end else if (tag_x_c == X_LAST) begin
          x_d = '0;
          y_d = tag_y_c + YW'(1);
        end else begin
          x_d = tag_x_c + XW'(1);
          y_d = tag_y_c;
        end
      end
    end
  end

  // Coordinate and framing state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q         <= '0;
      y_q         <= '0;
      locked_q    <= 1'b0;
      seen_sync_q <= 1'b0;
      drop_run_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      locked_q    <= locked_d;
      seen_sync_q <= seen_sync_d;
      drop_run_q  <= drop_run_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Stage 1: weighted products and tag flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_r_q     <= '0;
      s1_g_q     <= '0;
      s1_b_q     <= '0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_sof_q   <= 1'b0;
      s1_eol_q   <= 1'b0;
      s1_eof_q   <= 1'b0;
    end else if (advance_c) begin
      s1_valid_q <= keep_c;
      s1_r_q     <= PW'(r8_c) * COEF_R;
      s1_g_q     <= PW'(g8_c) * COEF_G;
      s1_b_q     <= PW'(b8_c) * COEF_B;
      s1_x_q     <= tag_x_c;
      s1_y_q     <= tag_y_c;
      s1_sof_q   <= (tag_x_c == '0) && (tag_y_c == '0);
      s1_eol_q   <= (tag_x_c == X_LAST);
      s1_eof_q   <= (tag_x_c == X_LAST) && (tag_y_c == Y_LAST);
    end
  end

  // Stage 2: coefficients sum to 256, so the top byte of the 16-bit sum is the luma
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_sof_q   <= 1'b0;
      out_eol_q   <= 1'b0;
      out_eof_q   <= 1'b0;
    end else if (advance_c) begin
      out_valid_q <= s1_valid_q;
      out_data_q  <= 8'((s1_r_q + s1_g_q + s1_b_q) >> 8);
      out_x_q     <= s1_x_q;
      out_y_q     <= s1_y_q;
      out_sof_q   <= s1_sof_q;
      out_eol_q   <= s1_eol_q;
      out_eof_q   <= s1_eof_q;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign out_sof   = out_sof_q;
  assign out_eol   = out_eol_q;
  assign out_eof   = out_eof_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_rgb565_gray_stream.sv
// Scoreboard bench for rgb565_gray_stream on a 4x2 frame: driver pushes expected pixels,
// a negedge monitor pops and compares, and also checks the stall and hold rules.
module tb_rgb565_gray_stream;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 2;
  localparam int unsigned XW = 2;
  localparam int unsigned YW = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_sync = 1'b0;
  logic [15:0]   in_data = 16'h0;
  logic          out_ready = 1'b1;
  logic          in_ready;
  logic          out_valid;
  logic [7:0]    out_data;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  logic          out_sof, out_eol, out_eof, frame_err;

  rgb565_gray_stream #(.WIDTH(W), .HEIGHT(H), .XW(XW), .YW(YW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_sync(in_sync), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_x(out_x), .out_y(out_y), .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]    d;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          sof;
    logic          eol;
    logic          eof;
  } px_t;

  // Hand-computed luma for each RGB565 vector
  logic [15:0] pix_tab [8] = '{16'hFFFF, 16'hF800, 16'h07E0, 16'h001F,
                               16'h0000, 16'h8410, 16'h7BEF, 16'h1234};
  logic [7:0]  lum_tab [8] = '{8'd255, 8'd76, 8'd149, 8'd28,
                               8'd0, 8'd130, 8'd124, 8'd63};

  px_t exp_q[$];
  int  n_vec = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  pops = 0;
  int  errs = 0;
  int  acc_cyc = 0;
  int  lat_acc = 0;
  bit  lat_arm = 1'b0;
  bit  bp_mode = 1'b0;
  bit  hold_v = 1'b0;
  px_t held;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) out_ready = ~out_ready;
    end
  end

  // Monitor: stall rule, hold stability, scoreboard pops, error pulse counting
  always @(negedge clk) begin
    px_t act;
    px_t e;
    act = {out_data, out_x, out_y, out_sof, out_eol, out_eof};
    if (!reset) begin
      hold_v = 1'b0;
    end else begin
      if (frame_err) errs++;
      chk("in_ready_rule", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (hold_v) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_payload", 32'(act), 32'(held));
      end
      hold_v = out_valid && !out_ready;
      held   = act;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("pixel", 32'(act), 32'(e));
          pops++;
          if (lat_arm) begin
            chk("first_latency", 32'(cyc - lat_acc), 32'd2);
            lat_arm = 1'b0;
          end
        end
      end
    end
  end

  task automatic send(input logic [15:0] d, input logic s);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_sync  = s;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      if (ok) acc_cyc = cyc;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_sync  = 1'b0;
    if (!ok) chk("accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic send_px(input int i, input logic s);
    px_t e;
    e.d   = lum_tab[i];
    e.x   = XW'(i % W);
    e.y   = YW'(i / W);
    e.sof = (i == 0);
    e.eol = ((i % W) == (W - 1));
    e.eof = (i == (W * H - 1));
    exp_q.push_back(e);
    send(pix_tab[i], s);
  endtask

  task automatic send_frame();
    for (int i = 0; i < W * H; i++) send_px(i, (i == 0));
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 80 && (exp_q.size() != 0 || out_valid); k++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int e0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_tags", 32'({out_x, out_y, out_sof, out_eol, out_eof}), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Basic frame, full throughput, first-pixel latency
    p0 = pops; e0 = errs;
    send_px(0, 1'b1);
    lat_acc = acc_cyc;
    lat_arm = 1'b1;
    for (int i = 1; i < W * H; i++) send_px(i, 1'b0);
    drain("t1_drain");
    chk("t1_count", 32'(pops - p0), 32'd8);
    chk("t1_err", 32'(errs - e0), 32'd0);
    chk("t1_latency_seen", 32'(lat_arm), 32'd0);

    // Backpressure with out_ready toggling
    p0 = pops; e0 = errs;
    bp_mode = 1'b1;
    send_frame();
    drain("t2_drain");
    bp_mode = 1'b0;
    out_ready = 1'b1;
    chk("t2_count", 32'(pops - p0), 32'd8);
    chk("t2_err", 32'(errs - e0), 32'd0);

    // Pre-sync discard after reset: no output, no error
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    p0 = pops; e0 = errs;
    for (int i = 0; i < 3; i++) send(16'h1234, 1'b0);
    send_frame();
    drain("t3_drain");
    chk("t3_count", 32'(pops - p0), 32'd8);
    chk("t3_err", 32'(errs - e0), 32'd0);

    // Short frame: sync + 3 pixels, then sync restarts
    p0 = pops; e0 = errs;
    send_px(0, 1'b1);
    for (int i = 1; i < 4; i++) send_px(i, 1'b0);
    send_frame();
    drain("t4_drain");
    chk("t4_count", 32'(pops - p0), 32'd12);
    chk("t4_err", 32'(errs - e0), 32'd1);

    // Overrun: two unsynced pixels after a full frame are dropped
    p0 = pops; e0 = errs;
    send_frame();
    send(16'hFFFF, 1'b0);
    send(16'h0000, 1'b0);
    drain("t5_drain");
    chk("t5_count", 32'(pops - p0), 32'd8);
    chk("t5_err", 32'(errs - e0), 32'd1);

    // Async reset with pipeline full
    out_ready = 1'b0;
    in_valid = 1'b1; in_sync = 1'b1; in_data = 16'hFFFF;
    @(posedge clk);
    #1;
    in_sync = 1'b0; in_data = 16'hF800;
    @(posedge clk);
    #1;
    chk("t6_pipe_full", 32'(out_valid), 32'd1);
    chk("t6_stalled", 32'(in_ready), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    p0 = pops; e0 = errs;
    send(16'hF800, 1'b0);
    send(16'h07E0, 1'b0);
    send_frame();
    drain("t6_drain");
    chk("t6_count", 32'(pops - p0), 32'd8);
    chk("t6_err", 32'(errs - e0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/rgb565_gray_stream.md
Name: rgb565_gray_stream

Overview:
- Downstream consumer of the camera capture stage's RGB565 pixel stream (valid/ready/sync/16-bit data).
- Converts each pixel to 8-bit luma through a stallable 2-stage pipeline.
- Tracks frame coordinates from the frame-sync marker and emits a gray pixel stream tagged with x/y and start-of-frame, end-of-line and end-of-frame flags for the feature-extraction stages.

Parameters:
- WIDTH, 640, active pixels per line
- HEIGHT, 480, active lines per frame
- XW, 10, out_x width (must satisfy 2^XW >= WIDTH)
- YW, 9, out_y width (must satisfy 2^YW >= HEIGHT)

Ports:
- clk  in  1  single clock for all logic
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- in_valid  in  1  upstream pixel valid
- in_ready  out  1  block accepts a pixel this cycle
- in_sync  in  1  qualifies the current in_data as the first pixel of a frame
- in_data  in  16  RGB565 pixel, R[15:11] G[10:5] B[4:0]
- out_valid  out  1  gray pixel valid
- out_ready  in  1  downstream accepts
- out_data  out  8  luma
- out_x  out  XW  column of out_data
- out_y  out  YW  row of out_data
- out_sof  out  1  pixel is (0,0)
- out_eol  out  1  pixel is x = WIDTH-1
- out_eof  out  1  pixel is (WIDTH-1, HEIGHT-1)
- frame_err  out  1  one-cycle pulse on a framing error

Behaviour:
- Reset (reset=0, async):
  - out_valid, frame_err, all stage-valid bits and the locked flag go to 0.
  - x/y counters, out_data, out_x, out_y, out_sof, out_eol and out_eof go to 0.
- Accept: a pixel is accepted when in_valid & in_ready.
- Stall rule:
  - advance = ~out_valid | out_ready; in_ready = advance.
  - All pipeline stages shift together on advance and hold otherwise; bubbles propagate as invalid.
  - in_ready may be 1 while out_valid = 0.
- Expansion to 8 bits: R8 = {R5, R5[4:2]}, G8 = {G6, G6[5:4]}, B8 = {B5, B5[4:2]}.
- Stage 1: register the products R8*77, G8*150 and B8*29, plus the coordinate tags.
- Stage 2: sum into 16 bits, out_data = sum[15:8].
  - The coefficients sum to 256, so no overflow; the maximum result is 255.
- Latency: an accepted pixel appears on out_valid 2 cycles after acceptance when out_ready stays high. Throughput is 1 pixel/cycle.
- Coordinate tracking, applied at acceptance:
  - in_sync=1: pixel is tagged (0,0), locked←1, counters restart at next position (1,0).
  - in_sync=1 while locked and counters not at (0,0) (i.e. a short frame): frame_err pulses for 1 cycle, then the same restart applies.
  - in_sync=0 and locked: tag with current (x,y). x increments; at WIDTH-1 it wraps to 0 and y increments.
  - After the tag (WIDTH-1, HEIGHT-1): locked←0 and counters return to (0,0).
  - in_sync=0 and not locked: pixel accepted and discarded; no output. frame_err pulses once per run of discarded pixels (on the first one), except before the first sync after reset, where no error is flagged.
- Flags: out_sof, out_eol and out_eof are computed from the tag in stage 1 and travel with the pixel. They are valid only with out_valid.
- Output holding: while out_valid & ~out_ready, all out_* signals hold stable.
- Simultaneous events: when sync arrives on the same cycle the pipeline stalls, nothing is accepted, so the sync is not consumed until in_ready=1.
- Reset mid-frame: pipeline contents are lost; the block waits for the next in_sync.

Test Plan:
- WIDTH=4, HEIGHT=2. Send a sync pixel, then 7 pixels 0xFFFF, 0xF800, 0x07E0, 0x001F, 0x0000, … with out_ready=1:
  - out_data is 255, 76, 149, 28, 0, …
  - First output appears 2 cycles after the first accept.
  - Tags run (0,0)…(3,1); sof on the 1st pixel, eol on the 4th and 8th, eof on the 8th.
- Backpressure: toggle out_ready 1010… over an 8-pixel frame.
  - No pixel lost or duplicated; outputs hold stable while stalled.
  - in_ready = 0 exactly when out_valid & ~out_ready.
- Pre-sync discard: after reset, send 3 pixels with in_sync=0, then a sync frame.
  - No output for the first 3; frame_err stays 0.
  - Sync pixel is emitted with sof, x=0, y=0.
- Short frame: sync, then 3 pixels, then sync.
  - frame_err pulses 1 cycle on the second sync accept.
  - That pixel is tagged (0,0) with sof.
- Overrun: a full 8-pixel frame followed by 2 unsynced pixels.
  - 8 outputs; the 2 extra pixels are dropped.
  - frame_err pulses exactly once.
- Async reset asserted mid-frame with the pipeline full:
  - out_valid drops to 0 immediately, without waiting for a clock edge.
  - After release, output resumes only after the next in_sync.
